mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_WORDS, 256, data RAM depth in 32-bit words.
- DATA_BASE, 32'h1001_0000, byte address of RAM word 0.
- MEM_LATENCY, 2, RAM access cycles; legal range 1..15.
REQ-002 clk  in  1  clock; all state in this block updates on the rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 BranchAddress_EX_MEM, JumpAddress_EX_MEM, ReadData1_EX_MEM  in  32 each  branch target, jump target, JR target.
REQ-005 ALUResult_EX_MEM  in  32  RAM byte address; ReadData2_EX_MEM  in  32  RAM write data.
REQ-006 BEQ_EX_MEM, BNE_EX_MEM, Zero_EX_MEM, J_EX_MEM, JAL_EX_MEM, JR_EX_MEM, MemRead_EX_MEM, MemWrite_EX_MEM  in  1 each  control from the EX/MEM register.
REQ-007 MemReadData  out  32  registered load result.
REQ-008 PCSrc  out  2  00 sequential, 01 branch, 10 jump (J/JAL), 11 JR.
REQ-009 PCTarget  out  32  redirect address; Redirect  out  1  PCSrc != 00.
REQ-010 Flush  out  1  squash IF/ID, ID/EX and EX/MEM contents.
REQ-011 Stall  out  1  active-high; drives Enable_EX_MEM and upstream enables low.
REQ-012 AddrError  out  1  current request is out of range or misaligned.

Function
REQ-013 Taken SHALL be (BEQ & Zero) | (BNE & ~Zero), computed combinationally.
REQ-014 PCSrc priority SHALL be JR > J/JAL > Taken > sequential.
REQ-015 PCTarget SHALL be ReadData1, JumpAddress or BranchAddress according to PCSrc, and 0 when PCSrc = 00.
REQ-016 Flush SHALL equal Redirect & ~Stall.
REQ-017 A request is MemRead | MemWrite.
REQ-018 A request is valid when the address is in [DATA_BASE, DATA_BASE + 4*DATA_WORDS) and address[1:0] = 0.
REQ-019 RAM word index SHALL be (address - DATA_BASE) >> 2.
REQ-020 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-021 IDLE with a valid request SHALL set Stall = 1 combinationally, go to ACCESS, and load the counter with MEM_LATENCY - 1.
REQ-022 ACCESS SHALL keep Stall = 1 and decrement the counter each cycle.
REQ-023 At the ACCESS edge where the counter is 0, the block SHALL perform the write, or capture the read into MemReadData, and go to DONE.
REQ-024 DONE SHALL hold Stall = 0 for exactly one cycle, then go to IDLE.
REQ-025 Each valid request SHALL therefore produce MEM_LATENCY + 1 stall cycles.
REQ-026 MemRead & MemWrite together SHALL be treated as a write, leaving MemReadData unchanged.
REQ-027 An invalid request SHALL cause no stall, no write and no state change; AddrError = 1 combinationally while it is presented, and MemReadData SHALL be set to 0 at the next edge.
REQ-028 In DONE, a newly presented request SHALL be ignored until IDLE; no access may be lost or duplicated.
REQ-029 MemReadData SHALL hold its value between loads.

Reset
REQ-030 Reset SHALL put the FSM in IDLE, clear the counter and set MemReadData = 0; Stall and AddrError then follow their combinational definitions.
REQ-031 Reset SHALL NOT clear RAM contents.
REQ-032 Reset during ACCESS SHALL abort the access with no write.
REQ-033 After reset deassertion the block SHALL accept a request in the first cycle.

Structure
REQ-034 Package mips_mem_pkg SHALL hold the FSM state type, the PCSrc encodings and the default DATA_BASE.
REQ-035 The RAM SHALL be a sub-module data_ram: synchronous write, asynchronous read, parameter DATA_WORDS.
REQ-036 The FSM, counter and PC-redirect logic SHALL reside in mem_stage.

Verification
REQ-037 Directed scenarios the bench SHALL cover:
- SW 0xDEADBEEF to 0x1001_0004, then LW 0x1001_0004 -> Stall high 3 cycles per op; MemReadData = 0xDEADBEEF after the LW's DONE.
- BEQ=1, Zero=1, BranchAddress = 0x0040_0020 -> PCSrc = 01, PCTarget = 0x0040_0020, Flush = 1; with Zero = 0, PCSrc = 00 and Flush = 0.
- JR=1 and J=1 together, ReadData1 = 0x0040_0100 -> PCSrc = 11, PCTarget = 0x0040_0100.
- LW 0x1001_0002, then LW 0x1000_FFFC -> AddrError = 1 each, Stall = 0, MemReadData = 0, RAM unchanged.
- Reset asserted mid-ACCESS of SW 0x1234 to 0x1001_0008 -> IDLE, Stall = 0, later LW of that word returns its prior value.
- Back-to-back LW/LW with MEM_LATENCY = 1 -> 2 stall cycles each, both values correct, exactly two RAM reads.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mips_mem_pkg;

   // Memory-access sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   // PC source select encodings.
   localparam logic [1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_JR     = 2'b11;

   // Byte address that maps to data RAM word 0 unless overridden.
   localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM control/data bundle into the MEM stage and the stage's results back out.
interface mem_stage_if;
   logic [31:0] BranchAddress_EX_MEM;
   logic [31:0] JumpAddress_EX_MEM;
   logic [31:0] ReadData1_EX_MEM;
   logic [31:0] ALUResult_EX_MEM;
   logic [31:0] ReadData2_EX_MEM;
   logic        BEQ_EX_MEM;
   logic        BNE_EX_MEM;
   logic        Zero_EX_MEM;
   logic        J_EX_MEM;
   logic        JAL_EX_MEM;
   logic        JR_EX_MEM;
   logic        MemRead_EX_MEM;
   logic        MemWrite_EX_MEM;

   logic [31:0] MemReadData;
   logic [1:0]  PCSrc;
   logic [31:0] PCTarget;
   logic        Redirect;
   logic        Flush;
   logic        Stall;
   logic        AddrError;

   // Pipeline side: presents EX/MEM contents, consumes stage results.
   modport master (
      output BranchAddress_EX_MEM, JumpAddress_EX_MEM, ReadData1_EX_MEM,
      output ALUResult_EX_MEM, ReadData2_EX_MEM,
      output BEQ_EX_MEM, BNE_EX_MEM, Zero_EX_MEM, J_EX_MEM, JAL_EX_MEM, JR_EX_MEM,
      output MemRead_EX_MEM, MemWrite_EX_MEM,
      input  MemReadData, PCSrc, PCTarget, Redirect, Flush, Stall, AddrError
   );

   // MEM stage side.
   modport slave (
      input  BranchAddress_EX_MEM, JumpAddress_EX_MEM, ReadData1_EX_MEM,
      input  ALUResult_EX_MEM, ReadData2_EX_MEM,
      input  BEQ_EX_MEM, BNE_EX_MEM, Zero_EX_MEM, J_EX_MEM, JAL_EX_MEM, JR_EX_MEM,
      input  MemRead_EX_MEM, MemWrite_EX_MEM,
      output MemReadData, PCSrc, PCTarget, Redirect, Flush, Stall, AddrError
   );
endinterface

// File: rtl/data_ram.sv
// Word-addressed data RAM: synchronous write, asynchronous read, no reset so
// contents survive a pipeline reset.
module data_ram #(
   parameter int unsigned DATA_WORDS = 256
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [$clog2(DATA_WORDS)-1:0] addr,
   input  logic [31:0]                   wdata,
   output logic [31:0]                   rdata
);

   logic [31:0] mem [DATA_WORDS];

   // Store the write word on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: PC redirect selection plus a multi-cycle data RAM
// access sequencer that stalls the pipeline while the RAM is busy.
module mem_stage
   import mips_mem_pkg::*;
#(
   parameter int unsigned DATA_WORDS  = 256,
   parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   mem_stage_if.slave bus
);

   localparam int unsigned AW       = $clog2(DATA_WORDS);
   // One past the last RAM byte, kept 33 bits wide so a region ending at
   // the top of the address space cannot wrap.
   localparam logic [32:0] LIMIT    = {1'b0, DATA_BASE} + 33'(4 * DATA_WORDS);
   localparam logic [3:0]  CNT_INIT = 4'(MEM_LATENCY - 1);

   mem_state_t  state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] rd_data_reg, rd_data_next;

   logic        taken;
   logic [1:0]  pc_src;
   logic [31:0] pc_target;
   logic        stall;
   logic        req, addr_ok, req_valid;
   logic [31:0] offset;
   logic [AW-1:0] word_idx;
   logic        ram_we;
   logic [31:0] ram_rdata;

   // Redirect select: JR beats J/JAL, which beats a taken branch.
   always_comb begin
      taken     = (bus.BEQ_EX_MEM & bus.Zero_EX_MEM) | (bus.BNE_EX_MEM & ~bus.Zero_EX_MEM);
      pc_src    = PCSRC_SEQ;
      pc_target = '0;
      if (bus.JR_EX_MEM) begin
         pc_src    = PCSRC_JR;
         pc_target = bus.ReadData1_EX_MEM;
      end else if (bus.J_EX_MEM | bus.JAL_EX_MEM) begin
         pc_src    = PCSRC_JUMP;
         pc_target = bus.JumpAddress_EX_MEM;
      end else if (taken) begin
         pc_src    = PCSRC_BRANCH;
         pc_target = bus.BranchAddress_EX_MEM;
      end
   end

   assign req       = bus.MemRead_EX_MEM | bus.MemWrite_EX_MEM;
   assign offset    = bus.ALUResult_EX_MEM - DATA_BASE;
   assign word_idx  = AW'(offset >> 2);
   assign addr_ok   = ({1'b0, bus.ALUResult_EX_MEM} >= {1'b0, DATA_BASE})
                    && ({1'b0, bus.ALUResult_EX_MEM} < LIMIT)
                    && (bus.ALUResult_EX_MEM[1:0] == 2'b00);
   assign req_valid = req & addr_ok;

   // Sequencer next state: stall from acceptance through the final access
   // cycle, then one unstalled DONE cycle so the held request is not re-run.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      rd_data_next = rd_data_reg;
      stall        = 1'b0;
      ram_we       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               stall      = 1'b1;
               state_next = ACCESS;
               cnt_next   = CNT_INIT;
            end else if (req) begin
               rd_data_next = '0;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (cnt_reg == 4'd0) begin
               state_next = DONE;
               if (bus.MemWrite_EX_MEM) begin
                  ram_we = 1'b1;
               end else if (bus.MemRead_EX_MEM) begin
                  rd_data_next = ram_rdata;
               end
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sequencer state, latency counter and load result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         rd_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         rd_data_reg <= rd_data_next;
      end
   end

   data_ram #(
      .DATA_WORDS (DATA_WORDS)
   ) u_data_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (word_idx),
      .wdata (bus.ReadData2_EX_MEM),
      .rdata (ram_rdata)
   );

   assign bus.PCSrc       = pc_src;
   assign bus.PCTarget    = pc_target;
   assign bus.Redirect    = (pc_src != PCSRC_SEQ);
   assign bus.Flush       = (pc_src != PCSRC_SEQ) & ~stall;
   assign bus.Stall       = stall;
   assign bus.AddrError   = req & ~addr_ok;
   assign bus.MemReadData = rd_data_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance at the default latency, one at
// latency 1 for the back-to-back load case.
module tb_mem_stage;
   import mips_mem_pkg::*;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   l1_rises = 0;
   logic l1_prev = 1'b0;

   mem_stage_if b0 ();
   mem_stage_if b1 ();

   mem_stage #(.DATA_WORDS(256), .DATA_BASE(32'h1001_0000), .MEM_LATENCY(2)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b0.slave)
   );

   mem_stage #(.DATA_WORDS(256), .DATA_BASE(32'h1001_0000), .MEM_LATENCY(1)) u_dut_l1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count stall bursts on the latency-1 instance (one per accepted access).
   always @(negedge clk) begin
      if (b1.Stall && !l1_prev) l1_rises <= l1_rises + 1;
      l1_prev <= b1.Stall;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic clear_bus();
      b0.BranchAddress_EX_MEM = '0; b0.JumpAddress_EX_MEM = '0; b0.ReadData1_EX_MEM = '0;
      b0.ALUResult_EX_MEM = '0; b0.ReadData2_EX_MEM = '0;
      b0.BEQ_EX_MEM = 0; b0.BNE_EX_MEM = 0; b0.Zero_EX_MEM = 0; b0.J_EX_MEM = 0;
      b0.JAL_EX_MEM = 0; b0.JR_EX_MEM = 0; b0.MemRead_EX_MEM = 0; b0.MemWrite_EX_MEM = 0;
      b1.BranchAddress_EX_MEM = '0; b1.JumpAddress_EX_MEM = '0; b1.ReadData1_EX_MEM = '0;
      b1.ALUResult_EX_MEM = '0; b1.ReadData2_EX_MEM = '0;
      b1.BEQ_EX_MEM = 0; b1.BNE_EX_MEM = 0; b1.Zero_EX_MEM = 0; b1.J_EX_MEM = 0;
      b1.JAL_EX_MEM = 0; b1.JR_EX_MEM = 0; b1.MemRead_EX_MEM = 0; b1.MemWrite_EX_MEM = 0;
   endtask

   task automatic set_req(input int d, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
      if (d == 0) begin
         b0.MemRead_EX_MEM = rd; b0.MemWrite_EX_MEM = wr;
         b0.ALUResult_EX_MEM = addr; b0.ReadData2_EX_MEM = data;
      end else begin
         b1.MemRead_EX_MEM = rd; b1.MemWrite_EX_MEM = wr;
         b1.ALUResult_EX_MEM = addr; b1.ReadData2_EX_MEM = data;
      end
   endtask

   // Present a request (called just after a rising edge), count stalled
   // cycles up to the DONE cycle, then return just after the following edge.
   task automatic mem_op(input int d, input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data, input int exp_stalls);
      int   n;
      logic s;
      set_req(d, rd, wr, addr, data);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s = (d == 0) ? b0.Stall : b1.Stall;
         if (s) n++;
         else break;
      end
      check({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
      @(posedge clk); #1;
   endtask

   // Present an out-of-range/misaligned request for one cycle.
   task automatic bad_op(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
      set_req(0, rd, wr, addr, data);
      @(negedge clk);
      check({tag, "_adderr"}, 32'(b0.AddrError), 32'd1);
      check({tag, "_stall"}, 32'(b0.Stall), 32'd0);
      @(posedge clk); #1;
      check({tag, "_rdata"}, b0.MemReadData, 32'h0);
      clear_bus();
   endtask

   initial begin
      int snap;
      reset = 1'b0;
      clear_bus();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rdata", b0.MemReadData, 32'h0);
      check("rst_stall", 32'(b0.Stall), 32'd0);
      check("rst_pcsrc", 32'(b0.PCSrc), 32'd0);
      check("rst_adderr", 32'(b0.AddrError), 32'd0);
      check("rst_rdata_l1", b1.MemReadData, 32'h0);

      // Request presented in the very first cycle after reset release.
      @(posedge clk); #1;
      reset = 1'b1;
      mem_op(0, "sw_beef", 1'b0, 1'b1, 32'h1001_0004, 32'hDEADBEEF, 3);
      mem_op(0, "lw_beef", 1'b1, 1'b0, 32'h1001_0004, 32'h0, 3);
      check("lw_beef_data", b0.MemReadData, 32'hDEADBEEF);
      clear_bus();
      repeat (2) @(posedge clk);
      #1;
      check("hold_data", b0.MemReadData, 32'hDEADBEEF);

      // PC redirect selection.
      b0.BEQ_EX_MEM = 1; b0.Zero_EX_MEM = 1; b0.BranchAddress_EX_MEM = 32'h0040_0020;
      #1;
      check("beq_pcsrc", 32'(b0.PCSrc), 32'h1);
      check("beq_target", b0.PCTarget, 32'h0040_0020);
      check("beq_flush", 32'(b0.Flush), 32'd1);
      check("beq_redirect", 32'(b0.Redirect), 32'd1);
      b0.Zero_EX_MEM = 0;
      #1;
      check("beq_nt_pcsrc", 32'(b0.PCSrc), 32'h0);
      check("beq_nt_flush", 32'(b0.Flush), 32'd0);
      check("beq_nt_target", b0.PCTarget, 32'h0);
      b0.BEQ_EX_MEM = 0; b0.BNE_EX_MEM = 1;
      #1;
      check("bne_pcsrc", 32'(b0.PCSrc), 32'h1);
      b0.JAL_EX_MEM = 1; b0.JumpAddress_EX_MEM = 32'h0040_0800;
      #1;
      check("jal_pcsrc", 32'(b0.PCSrc), 32'h2);
      check("jal_target", b0.PCTarget, 32'h0040_0800);
      b0.JAL_EX_MEM = 0; b0.J_EX_MEM = 1; b0.JR_EX_MEM = 1;
      b0.ReadData1_EX_MEM = 32'h0040_0100;
      #1;
      check("jr_pcsrc", 32'(b0.PCSrc), 32'h3);
      check("jr_target", b0.PCTarget, 32'h0040_0100);
      clear_bus();

      // A taken branch alongside a starting access must not flush while stalled.
      @(posedge clk); #1;
      b0.BEQ_EX_MEM = 1; b0.Zero_EX_MEM = 1; b0.BranchAddress_EX_MEM = 32'h0040_0040;
      set_req(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
      #1;
      check("br_stall_flush", 32'(b0.Flush), 32'd0);
      check("br_stall_redirect", 32'(b0.Redirect), 32'd1);
      mem_op(0, "br_lw", 1'b1, 1'b0, 32'h1001_0004, 32'h0, 3);
      clear_bus();

      // Invalid addresses: no stall, load result cleared, RAM untouched.
      bad_op("lw_misal", 1'b1, 1'b0, 32'h1001_0002, 32'h0);
      bad_op("lw_below", 1'b1, 1'b0, 32'h1000_FFFC, 32'h0);
      bad_op("sw_misal", 1'b0, 1'b1, 32'h1001_0006, 32'h0BAD_F00D);
      bad_op("sw_above", 1'b0, 1'b1, 32'h1001_0400, 32'h0BAD_F00D);
      mem_op(0, "lw_unch", 1'b1, 1'b0, 32'h1001_0004, 32'h0, 3);
      check("lw_unch_data", b0.MemReadData, 32'hDEADBEEF);

      // Last valid word.
      mem_op(0, "sw_top", 1'b0, 1'b1, 32'h1001_03FC, 32'hCAFE_F00D, 3);
      mem_op(0, "lw_top", 1'b1, 1'b0, 32'h1001_03FC, 32'h0, 3);
      check("lw_top_data", b0.MemReadData, 32'hCAFE_F00D);

      // Read+write together acts as a write only.
      mem_op(0, "rw", 1'b1, 1'b1, 32'h1001_000C, 32'h1357_9BDF, 3);
      check("rw_rdata_hold", b0.MemReadData, 32'hCAFE_F00D);
      mem_op(0, "lw_rw", 1'b1, 1'b0, 32'h1001_000C, 32'h0, 3);
      check("lw_rw_data", b0.MemReadData, 32'h1357_9BDF);

      // Reset in the middle of an access aborts the write.
      mem_op(0, "sw_prior", 1'b0, 1'b1, 32'h1001_0008, 32'h55AA_55AA, 3);
      set_req(0, 1'b0, 1'b1, 32'h1001_0008, 32'h0000_1234);
      @(negedge clk);
      check("abort_stall_idle", 32'(b0.Stall), 32'd1);
      @(negedge clk);
      check("abort_stall_acc", 32'(b0.Stall), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      clear_bus();
      #1;
      check("abort_stall", 32'(b0.Stall), 32'd0);
      check("abort_rdata", b0.MemReadData, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      mem_op(0, "lw_prior", 1'b1, 1'b0, 32'h1001_0008, 32'h0, 3);
      check("lw_prior_data", b0.MemReadData, 32'h55AA_55AA);
      clear_bus();

      // Latency 1: back-to-back loads, two stall cycles and one access each.
      mem_op(1, "l1_sw0", 1'b0, 1'b1, 32'h1001_0010, 32'h1111_2222, 2);
      mem_op(1, "l1_sw1", 1'b0, 1'b1, 32'h1001_0014, 32'h3333_4444, 2);
      clear_bus();
      @(posedge clk); #1;
      snap = l1_rises;
      mem_op(1, "l1_lw0", 1'b1, 1'b0, 32'h1001_0010, 32'h0, 2);
      check("l1_lw0_data", b1.MemReadData, 32'h1111_2222);
      mem_op(1, "l1_lw1", 1'b1, 1'b0, 32'h1001_0014, 32'h0, 2);
      check("l1_lw1_data", b1.MemReadData, 32'h3333_4444);
      clear_bus();
      repeat (2) @(negedge clk);
      check("l1_reads", 32'(l1_rises - snap), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
